// File: rtl/mr_ls.sv
// ============================================================================
// Module   : mr_ls
// Brief    : Load/store stage of the mr-soc integer pipeline. Performs at most
//            one data-memory access per instruction over a single-outstanding
//            req/ack bus and hands the result to writeback.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif
`ifndef REGSEL_BITS
`define REGSEL_BITS 5
`endif
`ifndef INSTID_BITS
`define INSTID_BITS 4
`endif

// Encodings of the enumerated inputs:
//   ls_memop : 0 = MEMOP_NONE, 1 = MEMOP_LOAD, 2 = MEMOP_STORE (3 behaves as NONE)
//   ls_size  : 0 = MEMSZ_1,    1 = MEMSZ_2,    2 = MEMSZ_4     (3 behaves as MEMSZ_4)
module mr_ls (
  input  logic                     clk,
  input  logic                     rst,
  // ALU stage side
  input  logic                     ls_valid,
  output logic                     ls_ready,
  input  logic [`INSTID_BITS-1:0]  ls_inst_id,
  input  logic [`XLEN-1:0]         ls_dest,
  input  logic [`REGSEL_BITS-1:0]  ls_dest_reg,
  input  logic [1:0]               ls_memop,
  input  logic [1:0]               ls_size,
  input  logic                     ls_signed,
  input  logic [`XLEN-1:0]         ls_payload,
  input  logic [1:0]               ls_payload_kind,
  input  logic                     ls_branch_taken,
  input  logic                     ls_branch_predicted,
  input  logic                     ls_is_jump,
  // Data memory bus
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [`XLEN-1:0]         mem_addr,
  output logic [`XLEN-1:0]         mem_wdata,
  output logic [3:0]               mem_wstrb,
  input  logic                     mem_ack,
  input  logic [`XLEN-1:0]         mem_rdata,
  // Writeback side
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [`INSTID_BITS-1:0]  wb_inst_id,
  output logic [`REGSEL_BITS-1:0]  wb_dest_reg,
  output logic [`XLEN-1:0]         wb_payload,
  output logic [1:0]               wb_payload_kind,
  output logic                     wb_branch_taken,
  output logic                     wb_branch_predicted,
  output logic                     wb_is_jump,
  output logic [`XLEN-1:0]         wb_data,
  output logic                     wb_misaligned
);

  localparam logic [1:0] MEMOP_LOAD  = 2'd1;
  localparam logic [1:0] MEMOP_STORE = 2'd2;
  localparam logic [1:0] MEMSZ_1     = 2'd0;
  localparam logic [1:0] MEMSZ_2     = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_size;
  logic             r_signed;
  logic             w_accept;
  logic             w_is_mem;
  logic             w_is_store;
  logic             w_misaligned;
  logic [3:0]       w_wstrb;
  logic [`XLEN-1:0] w_wdata;
  logic [`XLEN-1:0] w_shifted;
  logic [`XLEN-1:0] w_load_data;

  // A held result only blocks intake when writeback is not taking it, which
  // lets DONE hand off and accept the next instruction in the same cycle.
  assign ls_ready = (r_state != S_BUS) && (!wb_valid || wb_ready);
  assign wb_valid = (r_state == S_DONE);
  assign mem_req  = (r_state == S_BUS);

  assign w_accept     = ls_valid && ls_ready;
  assign w_is_store   = (ls_memop == MEMOP_STORE);
  assign w_is_mem     = (ls_memop == MEMOP_LOAD) || w_is_store;
  assign w_misaligned = w_is_mem &&
                        (((ls_size == MEMSZ_2) && ls_dest[0]) ||
                         ((ls_size != MEMSZ_1) && (ls_size != MEMSZ_2) && (ls_dest[1:0] != 2'b00)));

  // Store lane steering: strobes select the addressed bytes, data is replicated
  // so every lane carries the value regardless of offset.
  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = ls_payload;
    case (ls_size)
      MEMSZ_1: begin
        w_wstrb = 4'b0001 << ls_dest[1:0];
        w_wdata = {4{ls_payload[7:0]}};
      end
      MEMSZ_2: begin
        w_wstrb = 4'b0011 << ls_dest[1:0];
        w_wdata = {2{ls_payload[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = ls_payload;
      end
    endcase
  end

  // Load extraction; wb_data still holds the byte address while the bus is busy.
  always_comb begin
    w_shifted   = mem_rdata >> {wb_data[1:0], 3'b000};
    w_load_data = mem_rdata;
    case (r_size)
      MEMSZ_1: w_load_data = r_signed ? {{(`XLEN-8){w_shifted[7]}}, w_shifted[7:0]}
                                      : {{(`XLEN-8){1'b0}}, w_shifted[7:0]};
      MEMSZ_2: w_load_data = r_signed ? {{(`XLEN-16){w_shifted[15]}}, w_shifted[15:0]}
                                      : {{(`XLEN-16){1'b0}}, w_shifted[15:0]};
      default: w_load_data = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state: intake from IDLE or from DONE on handoff; BUS waits for ack.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept)
          w_state_nxt = (w_is_mem && !w_misaligned) ? S_BUS : S_DONE;
        else if (r_state == S_DONE && wb_ready)
          w_state_nxt = S_IDLE;
      end
      S_BUS: begin
        if (mem_ack) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture the instruction on accept, launch the bus access, and
  // fold the load word into wb_data when the ack arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_inst_id          <= '0;
      wb_dest_reg         <= '0;
      wb_payload          <= '0;
      wb_payload_kind     <= '0;
      wb_branch_taken     <= 1'b0;
      wb_branch_predicted <= 1'b0;
      wb_is_jump          <= 1'b0;
      wb_data             <= '0;
      wb_misaligned       <= 1'b0;
      r_size              <= '0;
      r_signed            <= 1'b0;
      mem_we              <= 1'b0;
      mem_addr            <= '0;
      mem_wdata           <= '0;
      mem_wstrb           <= '0;
    end else if (w_accept) begin
      wb_inst_id          <= ls_inst_id;
      wb_dest_reg         <= ls_dest_reg;
      wb_payload          <= ls_payload;
      wb_payload_kind     <= ls_payload_kind;
      wb_branch_taken     <= ls_branch_taken;
      wb_branch_predicted <= ls_branch_predicted;
      wb_is_jump          <= ls_is_jump;
      wb_data             <= ls_dest;
      wb_misaligned       <= w_misaligned;
      r_size              <= ls_size;
      r_signed            <= ls_signed;
      if (w_is_mem && !w_misaligned) begin
        mem_we    <= w_is_store;
        mem_addr  <= {ls_dest[`XLEN-1:2], 2'b00};
        mem_wdata <= w_wdata;
        mem_wstrb <= w_is_store ? w_wstrb : 4'b0000;
      end
    end else if (r_state == S_BUS && mem_ack) begin
      mem_we    <= 1'b0;
      mem_wstrb <= 4'b0000;
      if (!mem_we) wb_data <= w_load_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mr_ls.sv
// ============================================================================
// Module   : tb_mr_ls
// Brief    : Self-checking bench for mr_ls: vector table of single
//            instructions plus directed multi-cycle sequences.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif
`ifndef REGSEL_BITS
`define REGSEL_BITS 5
`endif
`ifndef INSTID_BITS
`define INSTID_BITS 4
`endif

module tb_mr_ls;

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] SZ1 = 2'd0;
  localparam logic [1:0] SZ2 = 2'd1;
  localparam logic [1:0] SZ4 = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid, ls_ready;
  logic [3:0]  ls_inst_id;
  logic [31:0] ls_dest;
  logic [4:0]  ls_dest_reg;
  logic [1:0]  ls_memop, ls_size;
  logic        ls_signed;
  logic [31:0] ls_payload;
  logic [1:0]  ls_payload_kind;
  logic        ls_branch_taken, ls_branch_predicted, ls_is_jump;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_inst_id;
  logic [4:0]  wb_dest_reg;
  logic [31:0] wb_payload, wb_data;
  logic [1:0]  wb_payload_kind;
  logic        wb_branch_taken, wb_branch_predicted, wb_is_jump, wb_misaligned;

  int n_cmp = 0;
  int n_bad = 0;

  mr_ls dut (
    .clk(clk), .rst(rst),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_inst_id(ls_inst_id),
    .ls_dest(ls_dest), .ls_dest_reg(ls_dest_reg), .ls_memop(ls_memop),
    .ls_size(ls_size), .ls_signed(ls_signed), .ls_payload(ls_payload),
    .ls_payload_kind(ls_payload_kind), .ls_branch_taken(ls_branch_taken),
    .ls_branch_predicted(ls_branch_predicted), .ls_is_jump(ls_is_jump),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_inst_id(wb_inst_id),
    .wb_dest_reg(wb_dest_reg), .wb_payload(wb_payload),
    .wb_payload_kind(wb_payload_kind), .wb_branch_taken(wb_branch_taken),
    .wb_branch_predicted(wb_branch_predicted), .wb_is_jump(wb_is_jump),
    .wb_data(wb_data), .wb_misaligned(wb_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  memop;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] dest;
    logic [31:0] payload;
    logic [31:0] rdata;
    int          k;         // edges from accept to ack
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic [3:0] id;
    logic [4:0] rd;
    logic [2:0] br;
    id = 4'(i + 3);
    rd = 5'(i + 1);
    br = 3'(i);
    ls_valid = 1'b1; ls_memop = v.memop; ls_size = v.size; ls_signed = v.sgn;
    ls_dest = v.dest; ls_payload = v.payload; ls_inst_id = id; ls_dest_reg = rd;
    ls_payload_kind = br[1:0]; ls_branch_taken = br[0];
    ls_branch_predicted = br[1]; ls_is_jump = br[2];
    wb_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_ls_ready", i), 32'(ls_ready), 32'd1);
    tick;
    ls_valid = 1'b0;
    chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(v.exp_req));
    if (v.exp_req) begin
      chk($sformatf("v%0d_mem_addr", i), mem_addr, v.exp_addr);
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(v.exp_we));
      chk($sformatf("v%0d_mem_wstrb", i), 32'(mem_wstrb), 32'(v.exp_wstrb));
      if (v.exp_we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v.exp_wdata);
      for (int c = 1; c < v.k; c++) begin
        mem_rdata = 32'h5A5A_5A5A;
        tick;
        chk($sformatf("v%0d_wait_req", i), 32'(mem_req), 32'd1);
        chk($sformatf("v%0d_wait_ls_ready", i), 32'(ls_ready), 32'd0);
      end
      mem_ack = 1'b1;
      mem_rdata = v.rdata;
      tick;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      chk($sformatf("v%0d_req_dropped", i), 32'(mem_req), 32'd0);
    end
    chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'd1);
    chk($sformatf("v%0d_wb_data", i), wb_data, v.exp_data);
    chk($sformatf("v%0d_wb_mis", i), 32'(wb_misaligned), 32'(v.exp_mis));
    chk($sformatf("v%0d_wb_tags", i),
        {16'h0, wb_inst_id, wb_dest_reg, wb_payload_kind, wb_branch_taken,
         wb_branch_predicted, wb_is_jump, 2'b0},
        {16'h0, id, rd, br[1:0], br[0], br[1], br[2], 2'b0});
    chk($sformatf("v%0d_wb_payload", i), wb_payload, v.payload);
    tick;
    chk($sformatf("v%0d_wb_drained", i), 32'(wb_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //             op        sz   s  dest          payload       rdata         k  req addr          we  strb     wdata         data          mis
    vecs[0]  = '{OP_LOAD,  SZ1, 1, 32'h0000_1003, 32'h0,        32'h80FF_1234, 3, 1, 32'h0000_1000, 0, 4'b0000, 32'h0,        32'hFFFF_FF80, 0};
    vecs[1]  = '{OP_LOAD,  SZ1, 0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 3, 1, 32'h0000_1000, 0, 4'b0000, 32'h0,        32'h0000_0080, 0};
    vecs[2]  = '{OP_STORE, SZ2, 0, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,        1, 1, 32'h0000_2000, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2002, 0};
    vecs[3]  = '{OP_LOAD,  SZ4, 0, 32'h0000_3001, 32'h0,        32'h0,         1, 0, 32'h0,         0, 4'b0000, 32'h0,        32'h0000_3001, 1};
    vecs[4]  = '{OP_LOAD,  SZ2, 1, 32'h0000_1002, 32'h0,        32'h80FF_1234, 2, 1, 32'h0000_1000, 0, 4'b0000, 32'h0,        32'hFFFF_80FF, 0};
    vecs[5]  = '{OP_LOAD,  SZ4, 1, 32'h0000_1004, 32'h0,        32'h1234_5678, 2, 1, 32'h0000_1004, 0, 4'b0000, 32'h0,        32'h1234_5678, 0};
    vecs[6]  = '{OP_STORE, SZ1, 0, 32'h0000_4001, 32'h0000_00A5, 32'h0,        1, 1, 32'h0000_4000, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_4001, 0};
    vecs[7]  = '{OP_STORE, SZ4, 0, 32'h0000_5000, 32'hCAFE_F00D, 32'h0,        4, 1, 32'h0000_5000, 1, 4'b1111, 32'hCAFE_F00D, 32'h0000_5000, 0};
    vecs[8]  = '{OP_STORE, SZ2, 0, 32'h0000_6003, 32'h1111_2222, 32'h0,        1, 0, 32'h0,         0, 4'b0000, 32'h0,        32'h0000_6003, 1};
    vecs[9]  = '{OP_LOAD,  SZ1, 0, 32'h0000_1001, 32'h0,        32'h80FF_1234, 1, 1, 32'h0000_1000, 0, 4'b0000, 32'h0,        32'h0000_0012, 0};
    vecs[10] = '{OP_NONE,  SZ4, 0, 32'h0000_7003, 32'h0BAD_F00D, 32'h0,        1, 0, 32'h0,         0, 4'b0000, 32'h0,        32'h0000_7003, 0};

    rst = 1'b0; ls_valid = 1'b0; ls_inst_id = '0; ls_dest = '0; ls_dest_reg = '0;
    ls_memop = OP_NONE; ls_size = SZ1; ls_signed = 1'b0; ls_payload = '0;
    ls_payload_kind = '0; ls_branch_taken = 1'b0; ls_branch_predicted = 1'b0;
    ls_is_jump = 1'b0; mem_ack = 1'b0; mem_rdata = '0; wb_ready = 1'b1;

    // Reset state
    repeat (3) tick;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b1;
    tick;

    // Single-instruction vectors
    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Back-to-back passthrough, one result per cycle, never touching the bus
    ls_valid = 1'b1; ls_memop = OP_NONE; ls_size = SZ4; wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ls_dest = 32'h10 + 32'(i);
      ls_inst_id = 4'(i);
      tick;
      chk($sformatf("b2b%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("b2b%0d_wb_data", i), wb_data, 32'h10 + 32'(i));
      chk($sformatf("b2b%0d_mem_req", i), 32'(mem_req), 32'd0);
    end
    ls_valid = 1'b0;
    tick;
    chk("b2b_drained", 32'(wb_valid), 32'd0);

    // Backpressure: result held for 5 cycles with a new instruction waiting
    wb_ready = 1'b0;
    ls_valid = 1'b1; ls_dest = 32'h0000_AAA0; ls_inst_id = 4'd5;
    tick;
    ls_dest = 32'h0000_BBB0; ls_inst_id = 4'd6;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_wb_valid", c), 32'(wb_valid), 32'd1);
      chk($sformatf("bp%0d_wb_data", c), wb_data, 32'h0000_AAA0);
      chk($sformatf("bp%0d_wb_id", c), 32'(wb_inst_id), 32'd5);
      chk($sformatf("bp%0d_ls_ready", c), 32'(ls_ready), 32'd0);
      tick;
    end
    wb_ready = 1'b1;
    #1;
    chk("bp_release_ls_ready", 32'(ls_ready), 32'd1);
    tick;
    ls_valid = 1'b0;
    chk("bp_next_wb_valid", 32'(wb_valid), 32'd1);
    chk("bp_next_wb_data", wb_data, 32'h0000_BBB0);
    chk("bp_next_wb_id", 32'(wb_inst_id), 32'd6);
    tick;
    chk("bp_drained", 32'(wb_valid), 32'd0);

    // Reset while a bus access is outstanding
    ls_valid = 1'b1; ls_memop = OP_LOAD; ls_size = SZ4; ls_dest = 32'h0000_8000;
    tick;
    ls_valid = 1'b0; ls_memop = OP_NONE;
    chk("rbus_req_before", 32'(mem_req), 32'd1);
    tick;
    rst = 1'b0;
    #1;
    chk("rbus_req_after", 32'(mem_req), 32'd0);
    chk("rbus_wb_valid", 32'(wb_valid), 32'd0);
    chk("rbus_mem_addr", mem_addr, 32'd0);
    tick;
    rst = 1'b1;
    #1;
    chk("rbus_ls_ready", 32'(ls_ready), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick;
    mem_ack = 1'b0;
    chk("spur_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("spur_ack_mem_req", 32'(mem_req), 32'd0);
    chk("spur_ack_wb_data", wb_data, 32'd0);
    chk("spur_ack_ls_ready", 32'(ls_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
